// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: round-robin arbiter sharing one mode-0 SPI master between flash (req[0]) and microSD (req[1]), with per-requester tx bytes, rx bytes and active-low chip selects
module spi_bus_arbiter #(
  parameter int CLK_DIV = 2,
  parameter int CS_GAP = 4
) (
  input  logic       clock_12mhz,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  input  logic [1:0] tx_valid,
  input  logic [7:0] tx_data0,
  input  logic [7:0] tx_data1,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       flash_cs,
  output logic       microsd_cs,
  output logic       flash_sclk,
  output logic       flash_mosi,
  input  logic       flash_miso
);
  localparam int CW = $clog2((CLK_DIV > CS_GAP ? CLK_DIV : CS_GAP) + 1);
  typedef enum logic [2:0] {IDLE, SELECT, HOLD, SHIFT, DESELECT} state_t;
  state_t state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0] bit_q;
  logic [7:0] sh_q, rsh_q, rx_data_q;
  logic [1:0] gnt_q;
  logic last_q, tx_ready_q, rx_valid_q, sclk_q, mosi_q;
  logic pick, div_end, grant_now;
  logic [7:0] tx_byte;
  assign pick = &req ? ~last_q : req[1];
  assign tx_byte = last_q ? tx_data1 : tx_data0;
  assign div_end = cnt_q == CW'(CLK_DIV - 1);
  assign grant_now = |req && (state_q == IDLE || (state_q == DESELECT && cnt_q == CW'(CS_GAP - 1)));
  always_ff @(posedge clock_12mhz) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      rsh_q <= '0;
      rx_data_q <= '0;
      gnt_q <= '0;
      last_q <= 1'b1;
      tx_ready_q <= 1'b0;
      rx_valid_q <= 1'b0;
      sclk_q <= 1'b0;
      mosi_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      case (state_q)
        SELECT: if (div_end) begin
          state_q <= HOLD;
          tx_ready_q <= 1'b1;
        end else cnt_q <= cnt_q + 1'b1;
        HOLD: if (!req[last_q]) begin
          state_q <= DESELECT;
          gnt_q <= '0;
          tx_ready_q <= 1'b0;
          cnt_q <= '0;
        end else if (tx_valid[last_q]) begin
          state_q <= SHIFT;
          tx_ready_q <= 1'b0;
          sh_q <= tx_byte;
          mosi_q <= tx_byte[7];
          cnt_q <= '0;
          bit_q <= '0;
        end
        SHIFT: if (!div_end) cnt_q <= cnt_q + 1'b1;
        else begin
          cnt_q <= '0;
          sclk_q <= ~sclk_q;
          if (!sclk_q) rsh_q <= {rsh_q[6:0], flash_miso};
          else begin
            bit_q <= bit_q + 1'b1;
            sh_q <= {sh_q[6:0], 1'b0};
            mosi_q <= sh_q[6];
            if (bit_q == 3'd7) begin
              state_q <= HOLD;
              tx_ready_q <= 1'b1;
              rx_valid_q <= 1'b1;
              rx_data_q <= rsh_q;
            end
          end
        end
        DESELECT: if (cnt_q == CW'(CS_GAP - 1)) state_q <= IDLE;
        else cnt_q <= cnt_q + 1'b1;
        default: state_q <= IDLE;
      endcase
      if (grant_now) begin
        state_q <= SELECT;
        gnt_q <= pick ? 2'b10 : 2'b01;
        last_q <= pick;
        cnt_q <= '0;
      end
    end
  end
  assign gnt = gnt_q;
  assign flash_cs = ~gnt_q[0];
  assign microsd_cs = ~gnt_q[1];
  assign tx_ready = tx_ready_q;
  assign rx_data = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign flash_sclk = sclk_q;
  assign flash_mosi = mosi_q;
endmodule
